mips_dmem_dump_reader: RTL and testbench

//  Hardware end-of-run result reader for single_cycle_mips.
//  - Watches the CPU PC. When PC reaches END_PC, it freezes the CPU and streams

---
 rtl/mips_dmem_dump_reader_if.sv | 24 ++
 rtl/mips_dmem_dump_reader.sv | 129 ++++++++++++
 tb/tb_mips_dmem_dump_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_dump_reader_if.sv
// ---------------------------------------------------------------------------
// mips_dmem_dump_reader_if
// Valid/ready stream that carries dumped data-memory words out of the
// end-of-run reader.
//   valid  : data/idx hold a word offered to the sink
//   ready  : sink accepts the word when valid & ready at a rising clock edge
//   data   : dumped dmem word (DATA_W bits)
//   idx    : offset of the word inside the dump window (IDX_W bits)
// Modports:
//   master : the reader (drives valid/data/idx, observes ready)
//   slave  : the sink   (observes valid/data/idx, drives ready)
// ---------------------------------------------------------------------------
interface mips_dmem_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  idx;

  modport master (output valid, output data, output idx, input ready);
  modport slave  (input valid, input data, input idx, output ready);
endinterface

// File: rtl/mips_dmem_dump_reader.sv
// ---------------------------------------------------------------------------
// mips_dmem_dump_reader
// End-of-run result reader for single_cycle_mips. Watches the CPU PC; once it
// reaches END_PC the CPU is frozen (halt_o) and DUMP_COUNT consecutive dmem
// words starting at word DUMP_BASE are streamed out over a valid/ready port.
// The block stays in DONE (CPU halted) until reset.
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset (0 = in reset)
//   pc_i           : current CPU PC (byte address)
//   halt_o         : registered; 1 = CPU holds PC and suppresses writes
//   dmem_rd_addr_o : dmem word index DUMP_BASE+idx (CPU mux uses it when halted)
//   dmem_rd_data_i : combinational dmem read data for dmem_rd_addr_o
//   dump           : valid/ready word stream (master side)
//   done_o         : all DUMP_COUNT words have been accepted
// IDX_W must satisfy 2**IDX_W >= DUMP_COUNT.
// ---------------------------------------------------------------------------
module mips_dmem_dump_reader #(
  parameter logic [31:0] END_PC     = 32'h9C,
  parameter int unsigned DUMP_BASE  = 50,
  parameter int unsigned DUMP_COUNT = 21,
  parameter int          DATA_W     = 32,
  parameter int          IDX_W      = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc_i,
  output logic                    halt_o,
  output logic [31:0]             dmem_rd_addr_o,
  input  logic [DATA_W-1:0]       dmem_rd_data_i,
  mips_dmem_dump_reader_if.master dump,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_COUNT - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              halt_q, halt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      halt_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      out_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      halt_q    <= halt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      out_idx_q <= out_idx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    out_idx_d = out_idx_q;
    done_d    = done_q;

    case (state_q)
      S_IDLE: begin
        if (pc_i == END_PC) state_d = S_DRAIN;
      end
      // One settling cycle so the END_PC instruction and any pending write
      // land in dmem before the first word is read.
      S_DRAIN: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d    = dmem_rd_data_i;
        out_idx_d = idx_q;
        valid_d   = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (dump.ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Halt is a flop that follows the next state, so it rises on the very
    // edge that samples the PC match.
    halt_d = (state_d != S_IDLE);
  end

  assign halt_o         = halt_q;
  assign dmem_rd_addr_o = 32'(DUMP_BASE) + 32'(idx_q);
  assign dump.valid     = valid_q;
  assign dump.data      = data_q;
  assign dump.idx       = out_idx_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_mips_dmem_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_mips_dmem_dump_reader
// Bench for mips_dmem_dump_reader. Instance u_dut0 uses the default window
// (END_PC=0x9C, base 50, 21 words); instance u_dut1 uses a single-word window
// at base 0. A behavioural dmem array backs each instance; the expected dump
// is simply mem[BASE+k] for k = 0..COUNT-1, accepted in order.
// ---------------------------------------------------------------------------
module tb_mips_dmem_dump_reader;

  localparam logic [31:0] END_PC = 32'h9C;
  localparam int BASE0  = 50;
  localparam int COUNT0 = 21;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance 0: default window ----------------
  logic [31:0] pc0 = 32'h0;
  logic        halt0;
  logic [31:0] addr0;
  logic [31:0] rdata0;
  logic        done0;
  logic [31:0] mem0 [0:127];

  mips_dmem_dump_reader_if #(.DATA_W(32), .IDX_W(5)) dif0 ();

  assign rdata0 = (addr0 < 32'd128) ? mem0[addr0[6:0]] : 32'hBAD0_0000;

  mips_dmem_dump_reader #(
    .END_PC(END_PC), .DUMP_BASE(BASE0), .DUMP_COUNT(COUNT0), .DATA_W(32), .IDX_W(5)
  ) u_dut0 (
    .clk(clk), .reset(reset), .pc_i(pc0), .halt_o(halt0),
    .dmem_rd_addr_o(addr0), .dmem_rd_data_i(rdata0), .dump(dif0), .done_o(done0)
  );

  // ---------------- instance 1: single word at base 0 ----------------
  logic [31:0] pc1 = 32'h0;
  logic        halt1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  logic        done1;
  logic [31:0] mem1 [0:3];

  mips_dmem_dump_reader_if #(.DATA_W(32), .IDX_W(1)) dif1 ();

  assign rdata1 = (addr1 < 32'd4) ? mem1[addr1[1:0]] : 32'hBAD1_0000;

  mips_dmem_dump_reader #(
    .END_PC(END_PC), .DUMP_BASE(0), .DUMP_COUNT(1), .DATA_W(32), .IDX_W(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .pc_i(pc1), .halt_o(halt1),
    .dmem_rd_addr_o(addr1), .dmem_rd_data_i(rdata1), .dump(dif1), .done_o(done1)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_window(input bit random_data);
    for (int i = 0; i < COUNT0; i++)
      mem0[BASE0 + i] = random_data ? $urandom : (32'h1000 + 32'(i));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    pc0 = 32'h0;
    dif0.ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // PC walks 0x98, 0xA0, 0x9C; returns at the negedge after the match edge E0.
  task automatic trigger();
    @(negedge clk);
    pc0 = 32'h98;
    @(negedge clk);
    check_eq("halt_before_match", 32'(halt0), 0);
    pc0 = 32'hA0;
    @(negedge clk);
    check_eq("halt_before_match", 32'(halt0), 0);
    pc0 = END_PC;
    @(negedge clk);
    check_eq("halt_after_e0", 32'(halt0), 1);
    $display("trigger: pc matched 0x%08h, halt=%0b", END_PC, halt0);
  endtask

  // Entered at the negedge after E0 (cyc=0 means "after E0").
  // mode 0: ready always 1; mode 1: ready about 1 cycle in 3.
  // abort_after > 0: return right after that many words have been accepted.
  task automatic run_dump(input int mode, input int abort_after);
    int          cyc = 0;
    int          k = 0;
    int          first_valid = -1;
    int          done_cyc = -1;
    bit          prev_stall = 1'b0;
    bit          rdy;
    logic [31:0] prev_data = '0;
    logic [31:0] prev_idx = '0;
    while (cyc < 2000) begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(dif0.valid), 1);
        check_eq("stall_data", dif0.data, prev_data);
        check_eq("stall_idx", 32'(dif0.idx), prev_idx);
      end
      check_eq("halt_during_dump", 32'(halt0), 1);
      if (done0) begin
        done_cyc = cyc;
        check_eq("valid_at_done", 32'(dif0.valid), 0);
        break;
      end
      if (dif0.valid && first_valid < 0) first_valid = cyc;
      rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      dif0.ready = rdy;
      pc0 = (cyc == 0 || $urandom_range(0, 3) == 0) ? END_PC : ($urandom & 32'hFFC);
      if (dif0.valid && rdy) begin
        if (k >= COUNT0) begin
          check_eq("extra_word_idx", 32'(dif0.idx), 32'(COUNT0 - 1));
        end else begin
          check_eq("word_data", dif0.data, mem0[BASE0 + k]);
          check_eq("word_idx", 32'(dif0.idx), 32'(k));
        end
        $display("word: k=%0d idx=%0d data=0x%08h cyc=%0d", k, dif0.idx, dif0.data, cyc);
        k++;
        if (abort_after > 0 && k == abort_after) begin
          @(posedge clk);
          return;
        end
      end
      prev_stall = dif0.valid && !rdy;
      prev_data  = dif0.data;
      prev_idx   = 32'(dif0.idx);
      @(negedge clk);
      cyc++;
    end
    check_eq("words_accepted", 32'(k), 32'(COUNT0));
    check_eq("done_seen", 32'(done_cyc >= 0), 1);
    if (mode == 0) begin
      check_eq("first_valid_cycle", 32'(first_valid), 2);
      check_eq("done_cycle", 32'(done_cyc), 32'(2 * COUNT0 + 1));
    end
    // DONE is terminal: PC at END_PC again must not restart anything.
    pc0 = END_PC;
    dif0.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_done_valid", 32'(dif0.valid), 0);
      check_eq("post_done_done", 32'(done0), 1);
      check_eq("post_done_halt", 32'(halt0), 1);
    end
    $display("dump: mode=%0d words=%0d done_cyc=%0d", mode, k, done_cyc);
  endtask

  initial begin
    dif0.ready = 1'b0;
    dif1.ready = 1'b0;
    for (int i = 0; i < 128; i++) mem0[i] = $urandom;
    for (int i = 0; i < 4; i++) mem1[i] = $urandom;
    mem1[0] = 32'hDEADBEEF;
    fill_window(1'b0);

    // Reset values, with the PC sitting on END_PC the whole time.
    pc0 = END_PC;
    repeat (3) @(negedge clk);
    check_eq("rst_halt", 32'(halt0), 0);
    check_eq("rst_valid", 32'(dif0.valid), 0);
    check_eq("rst_data", dif0.data, 0);
    check_eq("rst_idx", 32'(dif0.idx), 0);
    check_eq("rst_done", 32'(done0), 0);
    check_eq("rst_addr", addr0, 32'(BASE0));
    $display("reset: halt=%0b valid=%0b done=%0b", halt0, dif0.valid, done0);

    // PC held at END_PC across reset release: captured only at first edge.
    reset = 1'b1;
    #1;
    check_eq("release_halt", 32'(halt0), 0);
    @(negedge clk);
    check_eq("release_halt_e0", 32'(halt0), 1);
    run_dump(0, 0);

    // Nominal dump from PC sequence 0x98, 0xA0, 0x9C with ready held high.
    reset_pulse();
    trigger();
    run_dump(0, 0);

    // Random data and random ready.
    reset_pulse();
    fill_window(1'b1);
    trigger();
    run_dump(1, 0);

    // Reset after 7 accepted words, then a complete re-run from idx 0.
    reset_pulse();
    fill_window(1'b0);
    trigger();
    run_dump(0, 7);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_halt", 32'(halt0), 0);
    check_eq("async_rst_valid", 32'(dif0.valid), 0);
    check_eq("async_rst_data", dif0.data, 0);
    check_eq("async_rst_idx", 32'(dif0.idx), 0);
    check_eq("async_rst_done", 32'(done0), 0);
    check_eq("async_rst_addr", addr0, 32'(BASE0));
    $display("mid-dump reset: halt=%0b valid=%0b addr=%0d", halt0, dif0.valid, addr0);
    pc0 = 32'h0;
    dif0.ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    trigger();
    run_dump(1, 0);

    // Single-word window on instance 1.
    @(negedge clk);
    pc1 = END_PC;
    dif1.ready = 1'b0;
    @(negedge clk);
    check_eq("d1_halt_e0", 32'(halt1), 1);
    check_eq("d1_valid_drain", 32'(dif1.valid), 0);
    pc1 = 32'h0;
    @(negedge clk);
    check_eq("d1_valid_load", 32'(dif1.valid), 0);
    @(negedge clk);
    check_eq("d1_valid", 32'(dif1.valid), 1);
    check_eq("d1_data", dif1.data, 32'hDEADBEEF);
    check_eq("d1_idx", 32'(dif1.idx), 0);
    check_eq("d1_done_early", 32'(done1), 0);
    @(negedge clk);
    check_eq("d1_stall_valid", 32'(dif1.valid), 1);
    check_eq("d1_stall_data", dif1.data, 32'hDEADBEEF);
    dif1.ready = 1'b1;
    @(negedge clk);
    check_eq("d1_valid_after", 32'(dif1.valid), 0);
    check_eq("d1_done", 32'(done1), 1);
    check_eq("d1_halt_done", 32'(halt1), 1);
    $display("single-word: data=0x%08h done=%0b", dif1.data, done1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
